// File: rtl/convb_wm_sequencer_pkg.sv
// Shared definitions for the ConvB weight-memory read sequencer and the host-side WM writer.
// Both sides must agree on the kernel-slice layout, so the base-address rule lives here.
package convb_wm_sequencer_pkg;

    localparam int WM_KERNAL_SIZE      = 5;
    localparam int WM_IFM_DEPTH        = 3;
    localparam int WM_FILTERS_PER_UNIT = 3;
    localparam int NUMBER_OF_WM        = WM_KERNAL_SIZE * WM_KERNAL_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } wm_state_t;

    // Kernels are stored filter-major, then channel, each slice NUMBER_OF_WM words long.
    function automatic int unsigned wm_base_addr(
        input int unsigned filter,
        input int unsigned depth,
        input int unsigned ifm_depth,
        input int unsigned words
    );
        return (filter * ifm_depth + depth) * words;
    endfunction

endpackage

// File: rtl/convb_wm_sequencer.sv
// Reads one kernel slice from the unit's weight memory and shifts it into the weight FIFO,
// then holds kernel_ready until the layer controller acknowledges.
module convb_wm_sequencer
    import convb_wm_sequencer_pkg::*;
#(
    parameter  int KERNAL_SIZE      = WM_KERNAL_SIZE,
    parameter  int IFM_DEPTH        = WM_IFM_DEPTH,
    parameter  int FILTERS_PER_UNIT = WM_FILTERS_PER_UNIT,
    localparam int KERNEL_WORDS     = KERNAL_SIZE * KERNAL_SIZE,
    localparam int ADDRESS_SIZE_WM  = $clog2(KERNEL_WORDS * IFM_DEPTH * FILTERS_PER_UNIT),
    localparam int FSEL_W           = (FILTERS_PER_UNIT > 1) ? $clog2(FILTERS_PER_UNIT) : 1,
    localparam int DSEL_W           = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1,
    localparam int CNT_W            = $clog2(KERNEL_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [FSEL_W-1:0]          filter_sel,
    input  logic [DSEL_W-1:0]          depth_sel,
    input  logic                       kernel_ack,
    output logic                       busy,
    output logic                       kernel_ready,
    output logic                       sel_error,
    output logic                       wm_enable_read,
    output logic [ADDRESS_SIZE_WM-1:0] wm_address,
    output logic                       wm_fifo_enable
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_READY = READY;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_WORDS - 1);

    logic [1:0]                 state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [ADDRESS_SIZE_WM-1:0] addr_reg, addr_next;
    logic                       rd_reg, rd_next;
    logic                       fifo_en_reg;
    logic                       ready_reg, ready_next;
    logic                       err_reg, err_next;
    logic                       busy_reg, busy_next;

    logic                       sel_ok;
    logic [ADDRESS_SIZE_WM-1:0] start_base;

    assign sel_ok = (32'(filter_sel) < 32'(FILTERS_PER_UNIT)) &&
                    (32'(depth_sel)  < 32'(IFM_DEPTH));

    assign start_base = ADDRESS_SIZE_WM'(wm_base_addr(32'(filter_sel), 32'(depth_sel),
                                                      IFM_DEPTH, KERNEL_WORDS));

    // The address register itself carries base+cnt, so the base only needs latching once.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        rd_next    = 1'b0;
        ready_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        state_next = ST_READ;
                        cnt_next   = '0;
                        addr_next  = start_base;
                        rd_next    = 1'b1;
                    end else begin
                        err_next   = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DRAIN;
                end else begin
                    cnt_next  = cnt_reg + CNT_W'(1);
                    addr_next = addr_reg + ADDRESS_SIZE_WM'(1);
                    rd_next   = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_next = ST_READY;
                ready_next = 1'b1;
            end
            ST_READY: begin
                ready_next = 1'b1;
                if (kernel_ack) begin
                    ready_next = 1'b0;
                    if (start && sel_ok) begin
                        state_next = ST_READ;
                        cnt_next   = '0;
                        addr_next  = start_base;
                        rd_next    = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        err_next   = start;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            rd_reg      <= 1'b0;
            fifo_en_reg <= 1'b0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            rd_reg      <= rd_next;
            // WM data arrives one cycle after the read strobe.
            fifo_en_reg <= rd_reg;
            ready_reg   <= ready_next;
            err_reg     <= err_next;
            busy_reg    <= busy_next;
        end
    end

    assign busy           = busy_reg;
    assign kernel_ready   = ready_reg;
    assign sel_error      = err_reg;
    assign wm_enable_read = rd_reg;
    assign wm_address     = addr_reg;
    assign wm_fifo_enable = fifo_en_reg;

endmodule

// File: tb/tb_convb_wm_sequencer.sv
// Bench for convb_wm_sequencer: a WM model with one-cycle read latency feeds a 25-tap FIFO,
// and each load is checked against the address/shift/timing rules of a kernel load.
module tb_convb_wm_sequencer;

    localparam int NW  = 25;
    localparam int IFM = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] filter_sel;
    logic [1:0] depth_sel;
    logic       kernel_ack;
    logic       busy;
    logic       kernel_ready;
    logic       sel_error;
    logic       wm_enable_read;
    logic [7:0] wm_address;
    logic       wm_fifo_enable;

    int total = 0;
    int bad   = 0;

    logic [15:0] wm_mem [0:255];
    logic [15:0] rd_data;
    logic [15:0] taps [0:NW-1];
    int          shift_total = 0;

    convb_wm_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .filter_sel     (filter_sel),
        .depth_sel      (depth_sel),
        .kernel_ack     (kernel_ack),
        .busy           (busy),
        .kernel_ready   (kernel_ready),
        .sel_error      (sel_error),
        .wm_enable_read (wm_enable_read),
        .wm_address     (wm_address),
        .wm_fifo_enable (wm_fifo_enable)
    );

    always #5 clk = ~clk;

    // External WM (registered read) and the weight FIFO shift chain.
    always @(posedge clk) begin
        if (wm_enable_read) rd_data <= wm_mem[wm_address];
        if (wm_fifo_enable) begin
            taps[0] <= rd_data;
            for (int k = 1; k < NW; k++) taps[k] <= taps[k-1];
            shift_total <= shift_total + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outv();
        return {kernel_ready, busy, wm_enable_read, wm_fifo_enable, sel_error};
    endfunction

    // Issue a start (caller may already hold kernel_ack for a back-to-back load) and
    // check the whole load up to kernel_ready.
    task automatic load_and_check(input int f, input int d, input bit noise, input string tag);
        int exp_base, ready_cyc, first_fifo, last_fifo, shifts, err_seen, seq_bad, tap_bad;
        int rd_addr_q[$];
        int rd_cyc_q[$];
        exp_base   = (f * IFM + d) * NW;
        ready_cyc  = -1;
        first_fifo = -1;
        last_fifo  = -1;
        shifts     = 0;
        err_seen   = 0;
        filter_sel = 2'(f);
        depth_sel  = 2'(d);
        start      = 1'b1;
        tick();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (wm_enable_read) begin
                rd_addr_q.push_back(int'(wm_address));
                rd_cyc_q.push_back(cyc);
            end
            if (wm_fifo_enable) begin
                shifts++;
                if (first_fifo < 0) first_fifo = cyc;
                last_fifo = cyc;
            end
            if (sel_error) err_seen++;
            if (kernel_ready) begin
                ready_cyc = cyc;
                break;
            end
            start      = 1'b0;
            kernel_ack = 1'b0;
            if (noise) begin
                start      = 1'($urandom_range(0, 1));
                filter_sel = 2'($urandom_range(0, 3));
                depth_sel  = 2'($urandom_range(0, 3));
                if (wm_enable_read || wm_fifo_enable) kernel_ack = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start      = 1'b0;
        kernel_ack = 1'b0;
        seq_bad = 0;
        for (int k = 0; k < rd_addr_q.size(); k++)
            if (rd_addr_q[k] != exp_base + k || rd_cyc_q[k] != k) seq_bad++;
        tap_bad = 0;
        for (int k = 0; k < NW; k++)
            if (taps[NW-1-k] !== wm_mem[exp_base+k]) tap_bad++;
        $display("load %s: filter=%0d depth=%0d base=%0d reads=%0d shifts=%0d ready_cyc=%0d",
                 tag, f, d, exp_base, rd_addr_q.size(), shifts, ready_cyc);
        chk({tag, " read_count"}, rd_addr_q.size(), NW);
        chk({tag, " first_addr"}, (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1, exp_base);
        chk({tag, " addr_seq_errs"}, seq_bad, 0);
        chk({tag, " shifts"}, shifts, NW);
        chk({tag, " first_shift_cyc"}, first_fifo, 1);
        chk({tag, " last_shift_cyc"}, last_fifo, NW);
        chk({tag, " ready_cyc"}, ready_cyc, NW + 1);
        chk({tag, " sel_error_seen"}, err_seen, 0);
        chk({tag, " busy_in_ready"}, busy, 1);
        chk({tag, " fifo_tap_errs"}, tap_bad, 0);
        chk({tag, " tap_oldest"}, taps[NW-1], wm_mem[exp_base]);
        chk({tag, " tap_newest"}, taps[0], wm_mem[exp_base+NW-1]);
    endtask

    task automatic hold_ready(input int n, input bit noise, input string tag);
        for (int i = 0; i < n; i++) begin
            start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            filter_sel = 2'($urandom_range(0, 3));
            depth_sel  = 2'($urandom_range(0, 3));
            kernel_ack = 1'b0;
            tick();
            chk({tag, " hold_outputs"}, outv(), 5'b11000);
        end
        start = 1'b0;
    endtask

    task automatic ack_check(input int exp_addr, input string tag);
        start      = 1'b0;
        kernel_ack = 1'b1;
        tick();
        kernel_ack = 1'b0;
        $display("ack %s: busy=%0d ready=%0d addr=%0d", tag, busy, kernel_ready, wm_address);
        chk({tag, " after_ack"}, outv(), 5'b00000);
        chk({tag, " addr_held"}, wm_address, exp_addr);
    endtask

    task automatic bad_start(input int f, input int d, input string tag);
        filter_sel = 2'(f);
        depth_sel  = 2'(d);
        start      = 1'b1;
        tick();
        start = 1'b0;
        $display("bad start %s: filter=%0d depth=%0d sel_error=%0d", tag, f, d, sel_error);
        chk({tag, " err_pulse"}, outv(), 5'b00001);
        tick();
        chk({tag, " err_gone"}, outv(), 5'b00000);
    endtask

    initial begin
        int snap, fr, dr, reached;
        for (int i = 0; i < 256; i++) wm_mem[i] = 16'(i + 100);
        reset = 1'b1; start = 1'b0; kernel_ack = 1'b0;
        filter_sel = 2'd0; depth_sel = 2'd0;
        tick();
        tick();
        $display("reset: outputs=%b addr=%0d", outv(), wm_address);
        chk("reset outputs", outv(), 5'b00000);
        chk("reset addr", wm_address, 0);
        reset = 1'b0;
        tick();

        load_and_check(0, 0, 1'b0, "f0d0");
        ack_check(24, "f0d0");

        load_and_check(2, 1, 1'b0, "f2d1");
        hold_ready(2, 1'b0, "f2d1");
        ack_check(199, "f2d1");

        bad_start(0, 3, "depth3");
        bad_start(3, 0, "filter3");

        kernel_ack = 1'b1;
        tick();
        kernel_ack = 1'b0;
        chk("idle ack ignored", outv(), 5'b00000);

        load_and_check(0, 2, 1'b1, "noise");
        hold_ready(4, 1'b1, "noise");
        ack_check(74, "noise");

        snap = shift_total;
        load_and_check(2, 2, 1'b0, "b2b_a");
        kernel_ack = 1'b1;
        load_and_check(1, 0, 1'b0, "b2b_b");
        $display("b2b: shifts over two loads=%0d", shift_total - snap);
        chk("b2b total shifts", shift_total - snap, 2 * NW);
        ack_check(99, "b2b_b");

        filter_sel = 2'd0; depth_sel = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        reached = 0;
        for (int i = 0; i < 30; i++) begin
            if (wm_address == 8'd10) begin
                reached = 1;
                break;
            end
            tick();
        end
        chk("midreset reached cnt10", reached, 1);
        reset = 1'b1;
        tick();
        $display("midreset: outputs=%b addr=%0d", outv(), wm_address);
        chk("midreset outputs", outv(), 5'b00000);
        chk("midreset addr", wm_address, 0);
        reset = 1'b0;
        tick();
        chk("midreset quiet", outv(), 5'b00000);
        load_and_check(0, 0, 1'b0, "after_reset");
        ack_check(24, "after_reset");

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) wm_mem[i] = 16'($urandom_range(0, 65535));
            fr = $urandom_range(0, 2);
            dr = $urandom_range(0, 2);
            load_and_check(fr, dr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
            hold_ready($urandom_range(0, 3), 1'b1, $sformatf("rnd%0d", it));
            ack_check((fr * IFM + dr) * NW + NW - 1, $sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) == 1) bad_start(3, $urandom_range(0, 3), $sformatf("rndbad%0d", it));
            else bad_start($urandom_range(0, 3), 3, $sformatf("rndbad%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
